fifo_stream_reader: RTL and testbench

//   Read-side master for the team's synchronous FIFO (empty/rd_en/rdata/rd_error port set).

---
 rtl/fifo_stream_reader.sv | 113 +++++++++++
 tb/tb_fifo_stream_reader.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: drains it into a valid/ready stream
// through a 2-entry buffer that hides the FIFO read latency and consumer stalls.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_rd_en_o,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_rd_error_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] word_cnt_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     buf0_q, buf0_d;
    logic [WIDTH-1:0]     buf1_q, buf1_d;
    logic [1:0]           occ_q, occ_d;
    logic                 infl_q, infl_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 pop;
    logic                 rd_en;
    logic [1:0]           occ_pop;
    logic [2:0]           committed;

    always_comb begin
        pop       = (occ_q != 2'd0) & m_ready_i;
        // Words already owed to the buffer once this cycle's pop is taken.
        committed = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
        rd_en     = (state_q == RUN) & ~fifo_empty_i & ~rst_i
                  & (committed < 3'd2);
        occ_pop   = occ_q - {1'b0, pop};

        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (infl_q) begin
            if (occ_pop == 2'd0) begin
                buf0_d = fifo_rdata_i;
            end else begin
                buf1_d = fifo_rdata_i;
            end
        end

        occ_d  = occ_pop + {1'b0, infl_q};
        infl_d = rd_en;
        cnt_d  = cnt_q + CNT_WIDTH'(pop);
        err_d  = err_q | fifo_rd_error_i;

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) state_d = RUN;
            end
            RUN: begin
                if (!enable_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (enable_i) begin
                    state_d = RUN;
                end else if ((occ_q == 2'd0) && !infl_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            buf0_q  <= '0;
            buf1_q  <= '0;
            occ_q   <= 2'd0;
            infl_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            occ_q   <= occ_d;
            infl_q  <= infl_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign m_valid_o    = (occ_q != 2'd0);
    assign m_data_o     = buf0_q;
    assign busy_o       = (state_q != IDLE);
    assign word_cnt_o   = cnt_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO model and an in-order
// stream scoreboard driven with random data and consumer patterns.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fifo_empty = 1'b1;
    logic        rd_en;
    logic [7:0]  rdata = 8'h00;
    logic        rd_err;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        busy;
    logic [15:0] wcnt;
    logic        err;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (en),
        .fifo_empty_i   (fifo_empty),
        .fifo_rd_en_o   (rd_en),
        .fifo_rdata_i   (rdata),
        .fifo_rd_error_i(rd_err),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .m_data_o       (m_data),
        .busy_o         (busy),
        .word_cnt_o     (wcnt),
        .err_o          (err)
    );

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;
    int last_rd = 0;
    int deliv   = 0;
    int rd_base = 0;
    int deliv_base = 0;
    int occ_m;
    bit mon_on = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic [15:0] exp_cnt;

    // FIFO model: one-cycle read latency, empty flag registered.
    always @(posedge clk) begin
        last_rd = 0;
        if (rd_en === 1'b1 && fifo_q.size() > 0) begin
            rdata <= fifo_q.pop_front();
            rd_cnt++;
            last_rd = 1;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Stream scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            occ_m = (rd_cnt - rd_base) - last_rd - (deliv - deliv_base);
            n_tests++;
            if (occ_m < 0 || occ_m > 2) begin
                n_fail++;
                $display("FAIL occ_bound: got %0d required 0..2", occ_m);
            end
            n_tests++;
            if (m_valid !== (occ_m != 0)) begin
                n_fail++;
                $display("FAIL m_valid: got %b required %b", m_valid, occ_m != 0);
            end
            n_tests++;
            if (rd_en === 1'b1 && fifo_empty) begin
                n_fail++;
                $display("FAIL rd_on_empty: got rd_en=1 required 0");
            end
            exp_cnt = 16'(deliv - deliv_base);
            n_tests++;
            if (wcnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL word_cnt: got %0d required %0d", wcnt, exp_cnt);
            end
            if (prev_stall) begin
                n_tests++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b d=%h required v=1 d=%h",
                             m_valid, m_data, prev_data);
                end
            end
            if (m_valid === 1'b1 && m_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL data: got %h required no word", m_data);
                end else begin
                    if (m_data !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL data: got %h required %h", m_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                deliv++;
            end
            prev_stall = (m_valid === 1'b1) && !m_ready;
            prev_data  = m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rand(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            fifo_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic resync();
        rd_base    = rd_cnt;
        deliv_base = deliv;
        exp_q      = fifo_q;
        mon_on     = 1'b1;
    endtask

    task automatic wait_deliv(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (deliv >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (busy === 1'b0 && m_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1; en = 1'b1; m_ready = 1'b1; rd_err = 1'b0;
        push_rand(1);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if (rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rd_en: got %b required 0", rd_en);
            end
            n_tests++;
            if ({m_valid, m_data, busy, wcnt, err} !== 27'd0) begin
                n_fail++;
                $display("FAIL reset_outs: got v=%b d=%h b=%b c=%0d e=%b required 0",
                         m_valid, m_data, busy, wcnt, err);
            end
        end
        rst = 1'b0;
        resync();
        wait_deliv(deliv_base + 1, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL reset_first_word: got timeout required 1 word"); end
        en = 1'b0;
        wait_idle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL reset_idle: got busy required idle"); end
    endtask

    task automatic test_stream();
        bit ok;
        int base = deliv;
        int first_rd = -1;
        int first_v = -1;
        int end_c = -1;
        push_rand(16);
        en = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (deliv >= base + 16) begin
                end_c = c;
                break;
            end
            if (first_rd < 0 && rd_en === 1'b1) first_rd = c;
            if (first_v < 0 && m_valid === 1'b1) first_v = c;
            tick();
        end
        n_tests++;
        if (end_c < 0) begin n_fail++; $display("FAIL stream_done: got timeout required 16 words"); end
        n_tests++;
        if (first_v - first_rd != 2) begin
            n_fail++;
            $display("FAIL stream_latency: got %0d required 2", first_v - first_rd);
        end
        n_tests++;
        if (end_c - first_v != 16) begin
            n_fail++;
            $display("FAIL stream_rate: got %0d cycles required 16", end_c - first_v);
        end
        exp_cnt = 16'(base + 16 - deliv_base);
        n_tests++;
        if (wcnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL stream_cnt: got %0d required %0d", wcnt, exp_cnt);
        end
        tick();
        n_tests++;
        if (fifo_q.size() != 0 || fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_fifo_empty: got %0d words required 0", fifo_q.size());
        end
        en = 1'b0;
        wait_idle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL stream_idle: got busy required idle"); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int base = deliv;
        push_rand(16);
        en = 1'b1;
        for (int c = 0; c < 200 && deliv < base + 16; c++) begin
            m_ready = (c % 4 == 0) || (c % 4 == 3);
            tick();
        end
        n_tests++;
        if (deliv != base + 16) begin
            n_fail++;
            $display("FAIL bp_done: got %0d words required 16", deliv - base);
        end
        m_ready = 1'b1;
        en = 1'b0;
        wait_idle(ok);
        n_tests++;
        if (!ok || fifo_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_idle: got %0d left required 0", fifo_q.size());
        end
    endtask

    task automatic test_empty_gap();
        bit ok;
        int base = deliv;
        push_rand(4);
        en = 1'b1; m_ready = 1'b0;
        repeat (10) tick();
        n_tests++;
        if (m_valid !== 1'b1 || fifo_q.size() != 2 || deliv != base) begin
            n_fail++;
            $display("FAIL gap_stall: got v=%b left=%0d required v=1 left=2",
                     m_valid, fifo_q.size());
        end
        push_rand(4);
        m_ready = 1'b1;
        wait_deliv(base + 8, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL gap_done: got %0d required 8", deliv - base); end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL gap_err: got %b required 0", err); end
        en = 1'b0;
        wait_idle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL gap_idle: got busy required idle"); end
    endtask

    task automatic test_disable();
        bit ok;
        int base = deliv;
        int held;
        push_rand(16);
        en = 1'b1; m_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (m_valid === 1'b1 && deliv == base + 4) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        en = 1'b0;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL dis_fifth: got timeout required 5th word"); end
        wait_idle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL dis_busy: got busy=%b required 0", busy); end
        n_tests++;
        if (deliv - base - 5 > 2 || deliv - base < 5) begin
            n_fail++;
            $display("FAIL dis_extra: got %0d further required <=2", deliv - base - 5);
        end
        held = fifo_q.size();
        repeat (5) tick();
        n_tests++;
        if (fifo_q.size() != held || held + (deliv - base) != 16) begin
            n_fail++;
            $display("FAIL dis_retain: got %0d left required %0d", fifo_q.size(), 16 - (deliv - base));
        end
        en = 1'b1;
        wait_deliv(base + 16, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL dis_resume: got %0d required 16", deliv - base); end
        en = 1'b0;
        wait_idle(ok);
    endtask

    task automatic test_reset_err();
        bit ok;
        int left;
        push_rand(16);
        en = 1'b1; m_ready = 1'b0;
        repeat (8) tick();
        occ_m = (rd_cnt - rd_base) - last_rd - (deliv - deliv_base);
        n_tests++;
        if (m_valid !== 1'b1 || occ_m != 2) begin
            n_fail++;
            $display("FAIL rst_pre: got v=%b occ=%0d required v=1 occ=2", m_valid, occ_m);
        end
        rst = 1'b1; en = 1'b0; mon_on = 1'b0;
        tick();
        rst = 1'b0;
        n_tests++;
        if (m_valid !== 1'b0 || wcnt !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b c=%0d b=%b required 0", m_valid, wcnt, busy);
        end
        resync();
        left = fifo_q.size();
        en = 1'b1; m_ready = 1'b1;
        repeat (3) tick();
        rd_err = 1'b1;
        tick();
        rd_err = 1'b0;
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b required 1", err); end
        wait_deliv(deliv_base + left, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL err_drain: got %0d required %0d", deliv - deliv_base, left); end
        en = 1'b0;
        wait_idle(ok);
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b required 1", err); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; m_ready = 1'b0; rd_err = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_gap();
        test_disable();
        test_reset_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
